// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state encoding and default sizing for the SR config sequencer
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START1,
    WAIT1,
    START2,
    WAIT2,
    CHECK
  } sr_state_e;

  localparam int SR_WIDTH       = 170;
  localparam int SR_PASS_CYCLES = 200;

endpackage

// File: rtl/sr_config_sequencer_if.sv
// rtl/sr_config_sequencer_if.sv - request handshake and shift-register side signals
interface sr_config_sequencer_if
  import sr_pkg::*;
#(
  parameter int WIDTH       = SR_WIDTH,
  parameter int RETRY_WIDTH = 2
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic [WIDTH-1:0]       cfg_data;
  logic                   sr_start;
  logic [WIDTH-1:0]       sr_din;
  logic [WIDTH-1:0]       sr_dout;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [RETRY_WIDTH-1:0] retry_cnt;

  modport master (
    output req_valid, cfg_data, sr_dout,
    input  req_ready, sr_start, sr_din, busy, done, pass, retry_cnt
  );

  modport slave (
    input  req_valid, cfg_data, sr_dout,
    output req_ready, sr_start, sr_din, busy, done, pass, retry_cnt
  );

endinterface

// File: rtl/sr_pass_timer.sv
// rtl/sr_pass_timer.sv - loadable down-counter timing one shift pass; shared by both passes
module sr_pass_timer #(
  parameter int PASS_CYCLES = 200,
  parameter int CNT_WIDTH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam logic [CNT_WIDTH-1:0] LOAD_VAL = CNT_WIDTH'(PASS_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sr_config_sequencer.sv
// rtl/sr_config_sequencer.sv - writes one config word per request into the SR path.
// SR_SEQ_VERIFY_EN adds a second pass with readback compare and bounded retries.
module sr_config_sequencer
  import sr_pkg::*;
#(
  parameter int WIDTH       = SR_WIDTH,
  parameter int PASS_CYCLES = SR_PASS_CYCLES,
  parameter int CNT_WIDTH   = 8,
  parameter int RETRY_MAX   = 3,
  parameter int RETRY_WIDTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  sr_config_sequencer_if.slave bus
);

  sr_state_e              state_q;
  logic                   req_ready_q;
  logic                   sr_start_q;
  logic [WIDTH-1:0]       data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [RETRY_WIDTH-1:0] retry_q;
  logic                   timer_load;
  logic                   timer_expired;

  // Loading in the start cycle leaves PASS_CYCLES wait cycles before expiry.
  assign timer_load = (state_q == START1) || (state_q == START2);

  sr_pass_timer #(
    .PASS_CYCLES (PASS_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pass_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .expired_o (timer_expired)
  );

`ifdef SR_SEQ_VERIFY_EN
  localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(RETRY_MAX);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      sr_start_q  <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      sr_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            data_q      <= bus.cfg_data;
            pass_q      <= 1'b0;
            retry_q     <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            sr_start_q  <= 1'b1;
            state_q     <= START1;
          end
        end
        START1: state_q <= WAIT1;
        WAIT1: begin
          if (timer_expired) begin
`ifdef SR_SEQ_VERIFY_EN
            sr_start_q <= 1'b1;
            state_q    <= START2;
`else
            state_q    <= CHECK;
`endif
          end
        end
        START2: state_q <= WAIT2;
        WAIT2: begin
          if (timer_expired) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
`ifdef SR_SEQ_VERIFY_EN
          // Second pass shifts out what the first pass wrote, so it must equal data_q.
          if (bus.sr_dout == data_q) begin
            pass_q      <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_q    <= retry_q + 1'b1;
            sr_start_q <= 1'b1;
            state_q    <= START1;
          end else begin
            pass_q      <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
`else
          pass_q      <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.sr_start  = sr_start_q;
  assign bus.sr_din    = data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_sr_config_sequencer.sv
// tb/tb_sr_config_sequencer.sv - self-checking bench for sr_config_sequencer
`timescale 1ns/1ps
module tb_sr_config_sequencer;
  import sr_pkg::*;

  localparam int W       = 170;
  localparam int P       = 200;
  localparam int RW      = 2;
  localparam int RMAX    = 3;
  localparam int ATTEMPT = 2 * (P + 1) + 1;
  localparam int BOUND   = 3000;

  typedef struct {
    logic [W-1:0] cfg;
    bit           stuck;
    int           bad;
    bit           ep;
    int           er;
    int           elat;
    int           es;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_config_sequencer_if #(.WIDTH(W), .RETRY_WIDTH(RW)) bus ();

  sr_config_sequencer #(
    .WIDTH       (W),
    .PASS_CYCLES (P),
    .CNT_WIDTH   (8),
    .RETRY_MAX   (RMAX),
    .RETRY_WIDTH (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Shift-register model: each pass shifts out the previous content while loading sr_din.
  logic [W-1:0] sr_content = '0;
  logic [W-1:0] sr_prev;
  int           mdl_starts = 0;
  bit           mdl_stuck  = 1'b0;
  int           mdl_bad    = 0;

  always @(negedge clk) begin
    if (!bus.busy) mdl_starts = 0;
    if (bus.sr_start) begin
      sr_prev    = sr_content;
      sr_content = bus.sr_din;
      if (mdl_stuck) bus.sr_dout = '0;
      else if ((mdl_starts / 2) < mdl_bad) bus.sr_dout = sr_prev ^ W'(1);
      else bus.sr_dout = sr_prev;
      mdl_starts++;
    end
  end

  function automatic void predict(input logic [W-1:0] cfg, input bit stuck, input int bad,
                                  output bit p, output int r, output int lat, output int starts);
`ifdef SR_SEQ_VERIFY_EN
    bit ok;
    p = 1'b0;
    r = RMAX;
    for (int a = 0; a <= RMAX; a++) begin
      ok = stuck ? (cfg == '0) : (a >= bad);
      if (ok) begin
        p = 1'b1;
        r = a;
        break;
      end
    end
    lat    = (r + 1) * ATTEMPT + 1;
    starts = 2 * (r + 1);
`else
    p      = 1'b1;
    r      = 0;
    lat    = P + 3;
    starts = 1;
`endif
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < (W + 31) / 32; i++) w = {w[W-33:0], 32'($urandom)};
    return w;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    int lat = 0;
    int starts = 0;
    int din_err = 0;
    int rdy_err = 0;
    int s1 = -1;
    int s2 = -1;
    bit seen = 1'b0;
    @(negedge clk);
    mdl_stuck     = v.stuck;
    mdl_bad       = v.bad;
    bus.cfg_data  = v.cfg;
    bus.req_valid = 1'b1;
    check({tag, ".ready_idle"}, 256'(bus.req_ready), 256'(1));
    while (lat < BOUND) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus.req_valid = 1'b0;
        bus.cfg_data  = ~v.cfg;
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.sr_start) begin
        starts++;
        if (s1 < 0) s1 = lat;
        else if (s2 < 0) s2 = lat;
        if (bus.sr_din !== v.cfg) din_err++;
      end
      if (bus.req_ready || !bus.busy) rdy_err++;
    end
    check({tag, ".done_seen"}, 256'(seen), 256'(1));
    check({tag, ".latency"}, 256'(lat), 256'(v.elat));
    check({tag, ".pass"}, 256'(bus.pass), 256'(v.ep));
    check({tag, ".retry_cnt"}, 256'(bus.retry_cnt), 256'(v.er));
    check({tag, ".starts"}, 256'(starts), 256'(v.es));
    check({tag, ".first_start"}, 256'(s1), 256'(1));
`ifdef SR_SEQ_VERIFY_EN
    check({tag, ".start_gap"}, 256'(s2 - s1), 256'(P + 1));
`endif
    check({tag, ".din_stable"}, 256'(din_err), 256'(0));
    check({tag, ".busy_ready"}, 256'(rdy_err), 256'(0));
    check({tag, ".ready_at_done"}, 256'(bus.req_ready), 256'(1));
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 256'(bus.done), 256'(0));
    check({tag, ".pass_held"}, 256'(bus.pass), 256'(v.ep));
  endtask

  vec_t vecs[5];
  int   n_vec;

  initial begin
    vec_t rv;
    logic [W-1:0] ones;
    logic [W-1:0] a_word;
    logic [W-1:0] b_word;
    int lat;
    int rdy_err;
    int bad_evt;
    bit seen;

    ones          = '1;
    bus.req_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.sr_dout   = '0;

`ifdef SR_SEQ_VERIFY_EN
    vecs[0] = '{W'(1), 1'b0, 0, 1'b1, 0, 404, 2};
    vecs[1] = '{ones, 1'b1, 0, 1'b0, 3, 4 * ATTEMPT + 1, 8};
    vecs[2] = '{{W/2{2'b10}}, 1'b0, 1, 1'b1, 1, 2 * ATTEMPT + 1, 4};
    vecs[3] = '{{W/2{2'b01}}, 1'b0, 3, 1'b1, 3, 4 * ATTEMPT + 1, 8};
    vecs[4] = '{W'(170'h3c0ffee), 1'b0, 4, 1'b0, 3, 4 * ATTEMPT + 1, 8};
    n_vec = 5;
`else
    vecs[0] = '{W'(1), 1'b0, 0, 1'b1, 0, P + 3, 1};
    vecs[1] = '{ones, 1'b1, 0, 1'b1, 0, P + 3, 1};
    vecs[2] = '{{W/2{2'b10}}, 1'b0, 4, 1'b1, 0, P + 3, 1};
    n_vec = 3;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 256'(bus.req_ready), 256'(1));
    check("rst.sr_start", 256'(bus.sr_start), 256'(0));
    check("rst.sr_din", 256'(bus.sr_din), 256'(0));
    check("rst.busy", 256'(bus.busy), 256'(0));
    check("rst.done", 256'(bus.done), 256'(0));
    check("rst.pass", 256'(bus.pass), 256'(0));
    check("rst.retry_cnt", 256'(bus.retry_cnt), 256'(0));
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 8; i++) begin
      rv.cfg   = rand_word();
      rv.stuck = ($urandom_range(0, 7) == 0);
      rv.bad   = $urandom_range(0, 5);
      predict(rv.cfg, rv.stuck, rv.bad, rv.ep, rv.er, rv.elat, rv.es);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // req_valid held high: second word accepted in the done cycle
    a_word = rand_word();
    b_word = ~a_word;
    predict(a_word, 1'b0, 0, rv.ep, rv.er, rv.elat, rv.es);
    @(negedge clk);
    mdl_stuck     = 1'b0;
    mdl_bad       = 0;
    bus.cfg_data  = a_word;
    bus.req_valid = 1'b1;
    lat     = 0;
    rdy_err = 0;
    seen    = 1'b0;
    while (lat < BOUND) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) bus.cfg_data = b_word;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.req_ready) rdy_err++;
    end
    check("b2b.done_seen", 256'(seen), 256'(1));
    check("b2b.latency", 256'(lat), 256'(rv.elat));
    check("b2b.ready_low_busy", 256'(rdy_err), 256'(0));
    check("b2b.pass_first", 256'(bus.pass), 256'(1));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b.busy_again", 256'(bus.busy), 256'(1));
    check("b2b.ready_low", 256'(bus.req_ready), 256'(0));
    check("b2b.second_word", 256'(bus.sr_din), 256'(b_word));
    check("b2b.start_again", 256'(bus.sr_start), 256'(1));
    check("b2b.pass_cleared", 256'(bus.pass), 256'(0));
    check("b2b.retry_cleared", 256'(bus.retry_cnt), 256'(0));
    lat  = 0;
    seen = 1'b0;
    while (lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b.second_done", 256'(seen), 256'(1));
    check("b2b.second_pass", 256'(bus.pass), 256'(1));

    // reset during the first wait
    @(negedge clk);
    bus.cfg_data  = rand_word();
    bus.req_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check("abort.busy_before", 256'(bus.busy), 256'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.busy", 256'(bus.busy), 256'(0));
    check("abort.sr_start", 256'(bus.sr_start), 256'(0));
    check("abort.req_ready", 256'(bus.req_ready), 256'(1));
    check("abort.sr_din", 256'(bus.sr_din), 256'(0));
    check("abort.done", 256'(bus.done), 256'(0));
    rst = 1'b0;
    bad_evt = 0;
    for (int c = 0; c < 2 * ATTEMPT; c++) begin
      @(negedge clk);
      if (bus.done || bus.sr_start || bus.busy) bad_evt++;
    end
    check("abort.quiet_after", 256'(bad_evt), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
